// File: rtl/vga_sram_pkg.sv
// rtl/vga_sram_pkg.sv - shared defaults and state type for the VGA frame-buffer SRAM arbiter
package vga_sram_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int VGA_PIXELS = 307200;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_S,
        WR_P,
        CL_S,
        CL_P
    } arb_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_sram_arbiter.sv
// rtl/vga_sram_arbiter.sv - shares one async 16-bit frame-buffer SRAM between display reads, pixel writes and clear
module vga_sram_arbiter
    import vga_sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int BURST_LEN   = 8,
    parameter int CLEAR_WORDS = VGA_PIXELS
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic              iRESET_SYNC,
    input  logic              iRD_REQ,
    output logic              oRD_BUSY,
    input  logic [ADDR_W-1:0] iRD_ADDR,
    output logic              oRD_VALID,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oRD_LAST,
    input  logic              iWR_REQ,
    output logic              oWR_BUSY,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    input  logic              iCLR_REQ,
    input  logic [DATA_W-1:0] iCLR_DATA,
    output logic              oCLR_BUSY,
    output logic              onSRAM_CE,
    output logic              onSRAM_WE,
    output logic              onSRAM_OE,
    output logic              onSRAM_UB,
    output logic              onSRAM_LB,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [DATA_W-1:0] oSRAM_DATA,
    output logic              oSRAM_DATA_OE,
    input  logic [DATA_W-1:0] iSRAM_DATA
);

    localparam int BCNT_W = cnt_width(BURST_LEN);
    localparam int CCNT_W = cnt_width(CLEAR_WORDS);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
    localparam logic [CCNT_W-1:0] CLEAR_LAST = CCNT_W'(CLEAR_WORDS - 1);

    arb_state_t        state_q, state_d;
    logic              rd_busy_q, rd_busy_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_slot_q, rd_addr_slot_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic              wr_busy_q, wr_busy_d;
    logic [ADDR_W-1:0] wr_addr_slot_q, wr_addr_slot_d;
    logic [DATA_W-1:0] wr_data_slot_q, wr_data_slot_d;
    logic              clr_busy_q, clr_busy_d;
    logic [CCNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_data_q, clr_data_d;
    logic              fair_q, fair_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              bl_n_q, bl_n_d;
    logic              pad_oe_q, pad_oe_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;

    always_comb begin
        state_d        = state_q;
        rd_busy_d      = rd_busy_q;
        rd_pend_d      = rd_pend_q;
        rd_addr_slot_d = rd_addr_slot_q;
        burst_addr_d   = burst_addr_q;
        burst_cnt_d    = burst_cnt_q;
        wr_busy_d      = wr_busy_q;
        wr_addr_slot_d = wr_addr_slot_q;
        wr_data_slot_d = wr_data_slot_q;
        clr_busy_d     = clr_busy_q;
        clr_cnt_d      = clr_cnt_q;
        clr_data_d     = clr_data_q;
        fair_d         = fair_q;
        rd_valid_d     = 1'b0;
        rd_last_d      = 1'b0;
        rd_data_d      = rd_data_q;
        sram_addr_d    = sram_addr_q;
        sram_wdata_d   = sram_wdata_q;

        // The read slot stays occupied for one cycle past the final word.
        if (rd_last_q) begin
            rd_busy_d = 1'b0;
        end

        if (iRD_REQ && !rd_busy_q) begin
            rd_busy_d      = 1'b1;
            rd_pend_d      = 1'b1;
            rd_addr_slot_d = iRD_ADDR;
        end
        if (iWR_REQ && !wr_busy_q && !clr_busy_q) begin
            wr_busy_d      = 1'b1;
            wr_addr_slot_d = iWR_ADDR;
            wr_data_slot_d = iWR_DATA;
        end
        if (iCLR_REQ && !clr_busy_q) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
            clr_data_d = iCLR_DATA;
        end

        case (state_q)
            IDLE: begin
                if (fair_q && wr_busy_q) begin
                    state_d      = WR_S;
                    fair_d       = 1'b0;
                    sram_addr_d  = wr_addr_slot_q;
                    sram_wdata_d = wr_data_slot_q;
                end else if (rd_pend_q) begin
                    state_d      = RD_A;
                    rd_pend_d    = 1'b0;
                    burst_addr_d = rd_addr_slot_q;
                    burst_cnt_d  = '0;
                    sram_addr_d  = rd_addr_slot_q;
                end else if (wr_busy_q) begin
                    state_d      = WR_S;
                    sram_addr_d  = wr_addr_slot_q;
                    sram_wdata_d = wr_data_slot_q;
                end else if (clr_busy_q) begin
                    state_d      = CL_S;
                    sram_addr_d  = ADDR_W'(clr_cnt_q);
                    sram_wdata_d = clr_data_q;
                end
            end
            RD_A: state_d = RD_D;
            RD_D: begin
                rd_valid_d = 1'b1;
                rd_data_d  = iSRAM_DATA;
                if (burst_cnt_q == BURST_LAST) begin
                    rd_last_d = 1'b1;
                    state_d   = IDLE;
                    fair_d    = wr_busy_q;
                end else begin
                    // Bursts run RD_D -> RD_A without an idle gap so they are never split.
                    state_d      = RD_A;
                    burst_cnt_d  = burst_cnt_q + 1'b1;
                    burst_addr_d = burst_addr_q + 1'b1;
                    sram_addr_d  = burst_addr_q + 1'b1;
                end
            end
            WR_S: state_d = WR_P;
            WR_P: begin
                state_d   = IDLE;
                wr_busy_d = 1'b0;
                fair_d    = 1'b0;
            end
            CL_S: state_d = CL_P;
            CL_P: begin
                state_d = IDLE;
                if (clr_cnt_q == CLEAR_LAST) begin
                    clr_busy_d = 1'b0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ce_n_d   = (state_d == IDLE);
        oe_n_d   = !((state_d == RD_A) || (state_d == RD_D));
        we_n_d   = !((state_d == WR_P) || (state_d == CL_P));
        bl_n_d   = ce_n_d;
        pad_oe_d = (state_d == WR_S) || (state_d == WR_P) ||
                   (state_d == CL_S) || (state_d == CL_P);

        if (iRESET_SYNC) begin
            state_d        = IDLE;
            rd_busy_d      = 1'b0;
            rd_pend_d      = 1'b0;
            rd_addr_slot_d = '0;
            burst_addr_d   = '0;
            burst_cnt_d    = '0;
            wr_busy_d      = 1'b0;
            wr_addr_slot_d = '0;
            wr_data_slot_d = '0;
            clr_busy_d     = 1'b0;
            clr_cnt_d      = '0;
            clr_data_d     = '0;
            fair_d         = 1'b0;
            rd_valid_d     = 1'b0;
            rd_last_d      = 1'b0;
            rd_data_d      = '0;
            ce_n_d         = 1'b1;
            we_n_d         = 1'b1;
            oe_n_d         = 1'b1;
            bl_n_d         = 1'b1;
            pad_oe_d       = 1'b0;
            sram_addr_d    = '0;
            sram_wdata_d   = '0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q        <= IDLE;
            rd_busy_q      <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_addr_slot_q <= '0;
            burst_addr_q   <= '0;
            burst_cnt_q    <= '0;
            wr_busy_q      <= 1'b0;
            wr_addr_slot_q <= '0;
            wr_data_slot_q <= '0;
            clr_busy_q     <= 1'b0;
            clr_cnt_q      <= '0;
            clr_data_q     <= '0;
            fair_q         <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            rd_data_q      <= '0;
            ce_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            bl_n_q         <= 1'b1;
            pad_oe_q       <= 1'b0;
            sram_addr_q    <= '0;
            sram_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            rd_busy_q      <= rd_busy_d;
            rd_pend_q      <= rd_pend_d;
            rd_addr_slot_q <= rd_addr_slot_d;
            burst_addr_q   <= burst_addr_d;
            burst_cnt_q    <= burst_cnt_d;
            wr_busy_q      <= wr_busy_d;
            wr_addr_slot_q <= wr_addr_slot_d;
            wr_data_slot_q <= wr_data_slot_d;
            clr_busy_q     <= clr_busy_d;
            clr_cnt_q      <= clr_cnt_d;
            clr_data_q     <= clr_data_d;
            fair_q         <= fair_d;
            rd_valid_q     <= rd_valid_d;
            rd_last_q      <= rd_last_d;
            rd_data_q      <= rd_data_d;
            ce_n_q         <= ce_n_d;
            we_n_q         <= we_n_d;
            oe_n_q         <= oe_n_d;
            bl_n_q         <= bl_n_d;
            pad_oe_q       <= pad_oe_d;
            sram_addr_q    <= sram_addr_d;
            sram_wdata_q   <= sram_wdata_d;
        end
    end

    assign oRD_BUSY      = rd_busy_q;
    assign oRD_VALID     = rd_valid_q;
    assign oRD_DATA      = rd_data_q;
    assign oRD_LAST      = rd_last_q;
    assign oWR_BUSY      = wr_busy_q | clr_busy_q;
    assign oCLR_BUSY     = clr_busy_q;
    assign onSRAM_CE     = ce_n_q;
    assign onSRAM_WE     = we_n_q;
    assign onSRAM_OE     = oe_n_q;
    assign onSRAM_UB     = bl_n_q;
    assign onSRAM_LB     = bl_n_q;
    assign oSRAM_ADDR    = sram_addr_q;
    assign oSRAM_DATA    = sram_wdata_q;
    assign oSRAM_DATA_OE = pad_oe_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// tb/tb_vga_sram_arbiter.sv - self-checking bench for vga_sram_arbiter with an SRAM model and reference memory
module tb_vga_sram_arbiter;

    localparam int BL = 8;
    localparam int CW = 16;
    localparam logic [10:0] RST_VEC = 11'b11111_000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_sync = 1'b0;
    logic        rd_req = 1'b0, rd_busy, rd_valid, rd_last;
    logic [19:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0, wr_busy;
    logic [19:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        clr_req = 1'b0, clr_busy;
    logic [15:0] clr_data = '0;
    logic        ce_n, we_n, oe_n, ub_n, lb_n, pad_oe;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = 16'hDEAD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vga_sram_arbiter #(.ADDR_W(20), .DATA_W(16), .BURST_LEN(BL), .CLEAR_WORDS(CW)) dut (
        .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(rst_sync),
        .iRD_REQ(rd_req), .oRD_BUSY(rd_busy), .iRD_ADDR(rd_addr),
        .oRD_VALID(rd_valid), .oRD_DATA(rd_data), .oRD_LAST(rd_last),
        .iWR_REQ(wr_req), .oWR_BUSY(wr_busy), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
        .iCLR_REQ(clr_req), .iCLR_DATA(clr_data), .oCLR_BUSY(clr_busy),
        .onSRAM_CE(ce_n), .onSRAM_WE(we_n), .onSRAM_OE(oe_n), .onSRAM_UB(ub_n), .onSRAM_LB(lb_n),
        .oSRAM_ADDR(sram_addr), .oSRAM_DATA(sram_wdata), .oSRAM_DATA_OE(pad_oe),
        .iSRAM_DATA(sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [15:0] sram_mem [logic [19:0]];
    logic [15:0] ref_mem  [logic [19:0]];

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction
    function automatic logic [15:0] sram_peek(input logic [19:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
    endfunction
    function automatic logic [15:0] ref_peek(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Async SRAM: write latched while CE/WE are low, read data follows the address.
    always @(posedge clk) if (!ce_n && !we_n && pad_oe) sram_mem[sram_addr] = sram_wdata;
    always @(negedge clk) sram_rdata = (!ce_n && !oe_n) ? sram_peek(sram_addr) : 16'hDEAD;

    int          vq_cyc[$];
    logic [15:0] vq_data[$];
    logic        vq_last[$];
    logic [19:0] ra_q[$];
    logic [19:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];
    int          wrbusy_viol = 0;
    int          busy_drop_cyc = 0;
    logic        prev_oe_n = 1'b1, prev_rd_busy = 1'b0;
    logic [19:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rd_valid) begin
            vq_cyc.push_back(cyc);
            vq_data.push_back(rd_data);
            vq_last.push_back(rd_last);
        end
        if (!oe_n && (prev_oe_n || sram_addr != prev_addr)) ra_q.push_back(sram_addr);
        if (!we_n) begin
            wa_q.push_back(sram_addr);
            wd_q.push_back(sram_wdata);
            wc_q.push_back(cyc);
        end
        if (clr_busy && !wr_busy) wrbusy_viol++;
        if (prev_rd_busy && !rd_busy) busy_drop_cyc = cyc;
        prev_oe_n    = oe_n;
        prev_addr    = sram_addr;
        prev_rd_busy = rd_busy;
    end

    task automatic clear_logs();
        vq_cyc.delete(); vq_data.delete(); vq_last.delete();
        ra_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
        wrbusy_viol = 0;
    endtask

    task automatic preload(input logic [19:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] v;
            logic [19:0] a;
            v = 16'($urandom);
            a = base + 20'(i);
            sram_mem[a] = v;
            ref_mem[a]  = v;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(ce_n && !rd_busy && !wr_busy && !clr_busy) && k < 300) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (k >= 300) begin
            errors++;
            $display("FAIL idle_timeout: busy rd=%0b wr=%0b clr=%0b, required all 0", rd_busy, wr_busy, clr_busy);
        end
    endtask

    task automatic wait_valids(input int n, input int budget);
        int k = 0;
        while (vq_data.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (vq_data.size() < n) begin
            errors++;
            $display("FAIL valid_timeout: got %0d words, required %0d", vq_data.size(), n);
        end
    endtask

    task automatic issue_rd(input logic [19:0] a, output int t);
        @(negedge clk); rd_req = 1'b1; rd_addr = a;
        @(posedge clk); #1 t = cyc;
        @(negedge clk); rd_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] v;
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        v = {ce_n, we_n, oe_n, ub_n, lb_n, pad_oe, rd_valid, rd_last, rd_busy, wr_busy, clr_busy};
        checks++;
        if (v !== RST_VEC) begin errors++; $display("FAIL reset_flags: got %b required %b", v, RST_VEC); end
        checks++;
        if ({sram_addr, sram_wdata, rd_data} !== 52'd0) begin
            errors++; $display("FAIL reset_regs: addr %h wdata %h rdata %h required 0", sram_addr, sram_wdata, rd_data);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_burst();
        int t;
        wait_idle(); clear_logs(); preload(20'h00100, BL);
        issue_rd(20'h00100, t);
        wait_valids(BL, 60);
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < BL && i < vq_data.size(); i++) begin
            logic [19:0] a;
            a = 20'h00100 + 20'(i);
            checks++;
            if (vq_data[i] !== ref_peek(a) || vq_last[i] !== (i == BL - 1) || vq_cyc[i] != t + 3 + 2 * i) begin
                errors++;
                $display("FAIL single_word%0d: data %h last %b cyc %0d required %h %b %0d",
                         i, vq_data[i], vq_last[i], vq_cyc[i] - t, ref_peek(a), (i == BL - 1), 3 + 2 * i);
            end
            checks++;
            if (i >= ra_q.size() || ra_q[i] !== a) begin
                errors++; $display("FAIL single_addr%0d: got %h required %h", i, (i < ra_q.size()) ? ra_q[i] : 20'hxxxxx, a);
            end
        end
        checks++;
        if (busy_drop_cyc != t + 2 + 2 * BL) begin
            errors++; $display("FAIL single_busy_drop: cycle %0d required %0d", busy_drop_cyc - t, 2 + 2 * BL);
        end
    endtask

    task automatic test_rd_wr_same();
        int t;
        logic [19:0] base;
        wait_idle(); clear_logs();
        base = 20'h01000 + 20'($urandom_range(0, 'hF00));
        preload(base, BL);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = base; wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'h0F0F;
        @(posedge clk); #1 t = cyc;
        @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
        ref_mem[20'h00010] = 16'h0F0F;
        wait_valids(BL, 60);
        wait_idle();
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 20'h00010 || wd_q[0] !== 16'h0F0F) begin
            errors++; $display("FAIL rdwr_write: %0d writes first %h/%h required 1 write 00010/0f0f",
                               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 20'h0, (wd_q.size() > 0) ? wd_q[0] : 16'h0);
        end
        checks++;
        if (wc_q.size() == 0 || vq_cyc.size() < BL || wc_q[0] <= vq_cyc[BL - 1]) begin
            errors++; $display("FAIL rdwr_order: write did not follow the burst");
        end
        checks++;
        if (sram_peek(20'h00010) !== ref_peek(20'h00010)) begin
            errors++; $display("FAIL rdwr_mem: got %h required %h", sram_peek(20'h00010), ref_peek(20'h00010));
        end
        for (int i = 0; i < BL && i < vq_data.size(); i++) begin
            checks++;
            if (vq_data[i] !== ref_peek(base + 20'(i))) begin
                errors++; $display("FAIL rdwr_word%0d: got %h required %h", i, vq_data[i], ref_peek(base + 20'(i)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, k;
        logic [19:0] b1, b2, wa;
        logic [15:0] wd;
        wait_idle(); clear_logs();
        b1 = 20'h20000 + 20'($urandom_range(0, 'hFFF));
        b2 = 20'h28000 + 20'($urandom_range(0, 'hFFF));
        wa = 20'h30000 + 20'($urandom_range(0, 'hFFF));
        wd = 16'($urandom);
        preload(b1, BL); preload(b2, BL);
        issue_rd(b1, t1);
        wr_req = 1'b1; wr_addr = wa; wr_data = wd;
        @(negedge clk); wr_req = 1'b0;
        ref_mem[wa] = wd;
        k = 0;
        while (rd_busy && k < 100) begin @(negedge clk); #1; k++; end
        issue_rd(b2, t2);
        wait_valids(2 * BL, 80);
        wait_idle();
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== wa || wd_q[0] !== wd) begin
            errors++; $display("FAIL b2b_write: %0d writes, required one to %h with %h", wa_q.size(), wa, wd);
        end
        checks++;
        if (wc_q.size() == 0 || vq_cyc.size() < 2 * BL || wc_q[0] <= vq_cyc[BL - 1] || wc_q[0] >= vq_cyc[BL]) begin
            errors++; $display("FAIL b2b_order: write not placed between the two bursts");
        end
        for (int i = 0; i < 2 * BL && i < vq_data.size(); i++) begin
            logic [19:0] a;
            a = (i < BL) ? b1 + 20'(i) : b2 + 20'(i - BL);
            checks++;
            if (vq_data[i] !== ref_peek(a) || vq_last[i] !== (i == BL - 1 || i == 2 * BL - 1)) begin
                errors++; $display("FAIL b2b_word%0d: data %h last %b required %h %b",
                                   i, vq_data[i], vq_last[i], ref_peek(a), (i == BL - 1 || i == 2 * BL - 1));
            end
        end
    endtask

    task automatic test_clear();
        logic [15:0] old_v [CW];
        logic [15:0] color;
        int rb, k, t;
        wait_idle(); clear_logs();
        color = 16'h0ABC;
        for (int i = 0; i < CW; i++) old_v[i] = ref_peek(20'(i));
        rb = $urandom_range(0, CW - BL);
        @(negedge clk);
        clr_req = 1'b1; clr_data = color; wr_req = 1'b1; wr_addr = 20'h00003; wr_data = 16'h1234;
        @(negedge clk); clr_req = 1'b0; wr_req = 1'b0;
        ref_mem[20'h00003] = 16'h1234;
        repeat (4) @(negedge clk);
        issue_rd(20'(rb), t);
        #1;
        checks++;
        if (wr_busy !== 1'b1) begin errors++; $display("FAIL clear_wrbusy_now: got %b required 1", wr_busy); end
        wr_req = 1'b1; wr_addr = 20'h00005; wr_data = 16'h1111;
        @(negedge clk); wr_req = 1'b0;
        k = 0;
        while (clr_busy && k < 300) begin @(negedge clk); #1; k++; end
        wait_idle();
        for (int i = 0; i < CW; i++) ref_mem[20'(i)] = color;
        checks++;
        if (wa_q.size() != 1 + CW) begin errors++; $display("FAIL clear_count: %0d writes required %0d", wa_q.size(), 1 + CW); end
        checks++;
        if (wa_q.size() == 0 || wa_q[0] !== 20'h00003 || wd_q[0] !== 16'h1234) begin
            errors++; $display("FAIL clear_prior_write: captured write did not go first");
        end
        for (int i = 0; i < CW && i + 1 < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i + 1] !== 20'(i) || wd_q[i + 1] !== color) begin
                errors++; $display("FAIL clear_word%0d: %h/%h required %h/%h", i, wa_q[i + 1], wd_q[i + 1], 20'(i), color);
            end
        end
        for (int i = 0; i < CW; i++) begin
            checks++;
            if (sram_peek(20'(i)) !== ref_peek(20'(i))) begin
                errors++; $display("FAIL clear_mem%0d: got %h required %h", i, sram_peek(20'(i)), ref_peek(20'(i)));
            end
        end
        checks++;
        if (wrbusy_viol != 0) begin errors++; $display("FAIL clear_wrbusy: %0d cycles low required 0", wrbusy_viol); end
        checks++;
        if (vq_data.size() != BL || vq_last[BL - 1] !== 1'b1) begin
            errors++; $display("FAIL clear_read_len: %0d words required %0d with last", vq_data.size(), BL);
        end
        for (int i = 0; i < BL && i < vq_data.size(); i++) begin
            int a;
            a = rb + i;
            checks++;
            if (vq_data[i] !== old_v[a] && vq_data[i] !== color && !(a == 3 && vq_data[i] === 16'h1234)) begin
                errors++; $display("FAIL clear_read%0d: got %h required %h or %h", i, vq_data[i], old_v[a], color);
            end
        end
    endtask

    task automatic test_wrap();
        int t;
        wait_idle(); clear_logs(); preload(20'hFFFFE, BL);
        issue_rd(20'hFFFFE, t);
        wait_valids(BL, 60);
        for (int i = 0; i < BL && i < vq_data.size(); i++) begin
            logic [19:0] a;
            a = 20'hFFFFE + 20'(i);
            checks++;
            if (i >= ra_q.size() || ra_q[i] !== a || vq_data[i] !== ref_peek(a)) begin
                errors++; $display("FAIL wrap_word%0d: addr %h data %h required %h %h",
                                   i, (i < ra_q.size()) ? ra_q[i] : 20'h0, vq_data[i], a, ref_peek(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, k;
        logic [10:0] v;
        logic [19:0] b;
        // Async reset after the third burst word
        wait_idle(); clear_logs(); preload(20'h50000, BL);
        issue_rd(20'h50000, t);
        wait_valids(3, 40);
        #2 rst = 1'b1;
        #1 v = {ce_n, we_n, oe_n, ub_n, lb_n, pad_oe, rd_valid, rd_last, rd_busy, wr_busy, clr_busy};
        checks++;
        if (v !== RST_VEC) begin errors++; $display("FAIL rstmid_burst: got %b required %b", v, RST_VEC); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (vq_data.size() != 3 || vq_last[0] || vq_last[1] || vq_last[2]) begin
            errors++; $display("FAIL rstmid_dropped: %0d words after reset required 3 without last", vq_data.size());
        end
        // Async reset while WE is low
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 20'h60000 + 20'($urandom_range(0, 'hFF)); wr_data = 16'($urandom);
        @(negedge clk); wr_req = 1'b0;
        k = 0;
        #1;
        while (we_n && k < 20) begin @(negedge clk); #1; k++; end
        #2 rst = 1'b1;
        #1 v = {ce_n, we_n, oe_n, ub_n, lb_n, pad_oe, rd_valid, rd_last, rd_busy, wr_busy, clr_busy};
        checks++;
        if (k >= 20 || v !== RST_VEC) begin errors++; $display("FAIL rstmid_write: got %b required %b", v, RST_VEC); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Synchronous reset in the middle of a clear
        @(negedge clk);
        clr_req = 1'b1; clr_data = 16'($urandom);
        @(negedge clk); clr_req = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (clr_busy !== 1'b1) begin errors++; $display("FAIL rstsync_pre: clear busy %b required 1", clr_busy); end
        rst_sync = 1'b1;
        @(posedge clk); #1;
        v = {ce_n, we_n, oe_n, ub_n, lb_n, pad_oe, rd_valid, rd_last, rd_busy, wr_busy, clr_busy};
        checks++;
        if (v !== RST_VEC) begin errors++; $display("FAIL rstsync_flags: got %b required %b", v, RST_VEC); end
        @(negedge clk); rst_sync = 1'b0;
        // Normal service afterwards
        wait_idle(); clear_logs();
        b = 20'h70000 + 20'($urandom_range(0, 'hFFF));
        preload(b, BL);
        issue_rd(b, t);
        wait_valids(BL, 60);
        for (int i = 0; i < BL && i < vq_data.size(); i++) begin
            checks++;
            if (vq_data[i] !== ref_peek(b + 20'(i)) || vq_last[i] !== (i == BL - 1) || vq_cyc[i] != t + 3 + 2 * i) begin
                errors++; $display("FAIL rstmid_after%0d: data %h last %b required %h %b",
                                   i, vq_data[i], vq_last[i], ref_peek(b + 20'(i)), (i == BL - 1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_burst();
        test_rd_wr_same();
        test_back_to_back();
        test_clear();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
